// File: rtl/adder_pkg.sv
// adder_pkg: shared operation encoding and default sizing for the pipelined adder
package adder_pkg;
    typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_SAT_ADD, OP_SAT_SUB} op_e;
    localparam int DEF_WIDTH = 8;
    localparam int DEF_STAGES = 3;
    localparam int DEF_CNT_W = 16;
endpackage

// File: rtl/adder_if.sv
// adder_if: operand/result handshake bundle between the add env and adder_pipe
interface adder_if
    import adder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
);
    logic clear;
    logic in_valid;
    logic in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    op_e in_op;
    logic out_valid;
    logic out_ready;
    logic [WIDTH:0] out_sum;
    logic out_flag;
    logic [CNT_W-1:0] out_count;
    modport master (
        output clear, in_valid, in_a, in_b, in_op, out_ready,
        input in_ready, out_valid, out_sum, out_flag, out_count
    );
    modport slave (
        input clear, in_valid, in_a, in_b, in_op, out_ready,
        output in_ready, out_valid, out_sum, out_flag, out_count
    );
endinterface

// File: rtl/adder_alu.sv
// adder_alu: combinational unsigned add/sub/saturating add/saturating sub with carry, borrow or saturation flag
module adder_alu
    import adder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  op_e              op,
    output logic [WIDTH:0]   sum,
    output logic             flag
);
    logic [WIDTH:0] add_r;
    logic [WIDTH:0] sub_r;
    logic ovf;
    logic brw;
    assign add_r = {1'b0, a} + {1'b0, b};
    // the extra bit makes the difference come out modulo 2^(WIDTH+1)
    assign sub_r = {1'b0, a} - {1'b0, b};
    assign ovf = add_r[WIDTH];
    assign brw = a < b;
    assign sum = op == OP_ADD ? add_r :
                 op == OP_SUB ? sub_r :
                 op == OP_SAT_ADD ? (ovf ? {1'b0, {WIDTH{1'b1}}} : add_r) :
                 (brw ? '0 : sub_r);
    assign flag = (op == OP_ADD || op == OP_SAT_ADD) ? ovf : brw;
endmodule

// File: rtl/adder_pipe.sv
// adder_pipe: stall-all pipelined adder; ALU ahead of stage 0, STAGES result registers, output handshake counter
module adder_pipe
    import adder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int STAGES = DEF_STAGES,
    parameter int CNT_W = DEF_CNT_W
) (
    input logic clk,
    input logic rst_n,
    adder_if.slave bus
);
    logic [WIDTH:0] alu_sum;
    logic alu_flag;
    logic vld [STAGES];
    logic [WIDTH:0] sum_q [STAGES];
    logic flag_q [STAGES];
    logic [CNT_W-1:0] cnt;
    logic adv;
    adder_alu #(.WIDTH(WIDTH)) u_alu (
        .a(bus.in_a),
        .b(bus.in_b),
        .op(bus.in_op),
        .sum(alu_sum),
        .flag(alu_flag)
    );
    assign adv = !vld[STAGES-1] || bus.out_ready;
    assign bus.in_ready = adv;
    assign bus.out_valid = vld[STAGES-1];
    assign bus.out_sum = sum_q[STAGES-1];
    assign bus.out_flag = flag_q[STAGES-1];
    assign bus.out_count = cnt;
    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        logic v_in;
        logic [WIDTH:0] s_in;
        logic f_in;
        if (i == 0) begin : g_head
            assign v_in = bus.in_valid;
            assign s_in = alu_sum;
            assign f_in = alu_flag;
        end else begin : g_body
            assign v_in = vld[i-1];
            assign s_in = sum_q[i-1];
            assign f_in = flag_q[i-1];
        end
        // clear wins over advance so the offered pair is dropped too
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld[i] <= 1'b0;
                sum_q[i] <= '0;
                flag_q[i] <= 1'b0;
            end else begin
                if (bus.clear) vld[i] <= 1'b0;
                else if (adv) vld[i] <= v_in;
                if (adv) begin
                    sum_q[i] <= s_in;
                    flag_q[i] <= f_in;
                end
            end
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt <= '0;
        else if (vld[STAGES-1] && bus.out_ready) cnt <= cnt + 1'b1;
    end
endmodule

// File: tb/tb_adder_pipe.sv
// tb_adder_pipe: three configurations share one stimulus stream; each is checked every cycle against a queue model
module tb_adder_pipe;
    import adder_pkg::*;
    typedef struct {logic [8:0] sum; logic flag; int age;} ent_t;
    localparam int ST [3] = '{3, 3, 1};
    localparam int CW [3] = '{16, 4, 16};
    logic clk = 0, rst_n = 0, clear = 0, in_valid = 0, out_ready = 1;
    logic [7:0] in_a = 0, in_b = 0;
    op_e in_op = OP_ADD;
    logic d_valid [3], d_ready [3], d_flag [3];
    logic [8:0] d_sum [3];
    logic [15:0] d_cnt [3];
    ent_t q [3][$];
    int mcnt [3];
    int n_cmp = 0, n_err = 0;
    always #5 clk = ~clk;
    for (genvar g = 0; g < 3; g++) begin : gi
        adder_if #(.WIDTH(8), .CNT_W(g == 1 ? 4 : 16)) bus ();
        assign bus.clear = clear;
        assign bus.in_valid = in_valid;
        assign bus.in_a = in_a;
        assign bus.in_b = in_b;
        assign bus.in_op = in_op;
        assign bus.out_ready = out_ready;
        adder_pipe #(.WIDTH(8), .STAGES(g == 2 ? 1 : 3), .CNT_W(g == 1 ? 4 : 16)) dut (
            .clk(clk), .rst_n(rst_n), .bus(bus));
        assign d_valid[g] = bus.out_valid;
        assign d_ready[g] = bus.in_ready;
        assign d_sum[g] = bus.out_sum;
        assign d_flag[g] = bus.out_flag;
        assign d_cnt[g] = 16'(bus.out_count);
    end
    function automatic ent_t ref_op(int a, int b, op_e op);
        ent_t e;
        int s;
        case (op)
            OP_ADD: begin s = a + b; e.flag = s > 255; end
            OP_SUB: begin s = (a - b + 512) % 512; e.flag = a < b; end
            OP_SAT_ADD: begin s = (a + b > 255) ? 255 : a + b; e.flag = a + b > 255; end
            default: begin s = (a < b) ? 0 : a - b; e.flag = a < b; end
        endcase
        e.sum = 9'(s);
        e.age = 1;
        return e;
    endfunction
    task automatic chk(string nm, int g, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[%0d]: got %0h expected %0h at %0t", nm, g, act, exp, $time);
        end
    endtask
    function automatic bit head_ready(int g);
        return q[g].size() > 0 && q[g][0].age == ST[g];
    endfunction
    task automatic model_edge();
        ent_t e;
        bit ev;
        for (int g = 0; g < 3; g++) begin
            ev = head_ready(g);
            if (ev && out_ready) begin
                void'(q[g].pop_front());
                mcnt[g] = (mcnt[g] + 1) % (1 << CW[g]);
            end
            if (clear) q[g].delete();
            else if (!ev || out_ready) begin
                for (int i = 0; i < q[g].size(); i++) begin
                    e = q[g][i];
                    e.age++;
                    q[g][i] = e;
                end
                if (in_valid) q[g].push_back(ref_op(int'(in_a), int'(in_b), in_op));
            end
        end
    endtask
    task automatic compare();
        bit ev;
        for (int g = 0; g < 3; g++) begin
            ev = head_ready(g);
            chk("out_valid", g, 32'(d_valid[g]), 32'(ev));
            chk("in_ready", g, 32'(d_ready[g]), 32'(!ev || out_ready));
            chk("out_count", g, 32'(d_cnt[g]), 32'(mcnt[g]));
            if (ev) begin
                chk("out_sum", g, 32'(d_sum[g]), 32'(q[g][0].sum));
                chk("out_flag", g, 32'(d_flag[g]), 32'(q[g][0].flag));
            end
        end
    endtask
    task automatic tick();
        @(posedge clk);
        if (rst_n) model_edge();
        @(negedge clk);
        if (rst_n) compare();
    endtask
    task automatic step(logic v, int a, int b, op_e op);
        in_valid = v;
        in_a = 8'(a);
        in_b = 8'(b);
        in_op = op;
        tick();
    endtask
    task automatic model_reset();
        for (int g = 0; g < 3; g++) begin
            q[g].delete();
            mcnt[g] = 0;
        end
    endtask
    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        for (int g = 0; g < 3; g++) begin
            chk("rst_valid", g, 32'(d_valid[g]), 0);
            chk("rst_sum", g, 32'(d_sum[g]), 0);
            chk("rst_flag", g, 32'(d_flag[g]), 0);
            chk("rst_count", g, 32'(d_cnt[g]), 0);
        end
        rst_n = 1;
        // single ADD, latency and first count
        step(1, 200, 100, OP_ADD);
        chk("t1_s1_sum", 2, 32'(d_sum[2]), 32'h12C);
        step(0, 0, 0, OP_ADD);
        chk("t1_early", 0, 32'(d_valid[0]), 0);
        step(0, 0, 0, OP_ADD);
        chk("t1_valid", 0, 32'(d_valid[0]), 1);
        chk("t1_sum", 0, 32'(d_sum[0]), 32'h12C);
        chk("t1_flag", 0, 32'(d_flag[0]), 1);
        step(0, 0, 0, OP_ADD);
        chk("t1_count", 0, 32'(d_cnt[0]), 1);
        // back-to-back mixed ops
        step(1, 5, 7, OP_SUB);
        step(1, 250, 10, OP_SAT_ADD);
        step(1, 3, 9, OP_SAT_SUB);
        chk("t2_sub", 0, 32'(d_sum[0]), 32'h1FE);
        chk("t2_sub_f", 0, 32'(d_flag[0]), 1);
        step(0, 0, 0, OP_ADD);
        chk("t2_sadd", 0, 32'(d_sum[0]), 255);
        chk("t2_sadd_f", 0, 32'(d_flag[0]), 1);
        step(0, 0, 0, OP_ADD);
        chk("t2_ssub", 0, 32'(d_sum[0]), 0);
        chk("t2_ssub_f", 0, 32'(d_flag[0]), 1);
        step(0, 0, 0, OP_ADD);
        chk("t2_count", 0, 32'(d_cnt[0]), 4);
        // stream with a four-cycle downstream stall
        for (int i = 0; i < 3; i++) step(1, 10 * i + 1, i + 2, OP_ADD);
        out_ready = 0;
        for (int k = 0; k < 4; k++) begin
            step(1, 31, 5, OP_ADD);
            chk("t3_stall_rdy", 0, 32'(d_ready[0]), 0);
            chk("t3_hold", 0, 32'(d_sum[0]), 3);
        end
        out_ready = 1;
        for (int i = 3; i < 6; i++) step(1, 10 * i + 1, i + 2, OP_ADD);
        repeat (4) step(0, 0, 0, OP_ADD);
        chk("t3_count", 0, 32'(d_cnt[0]), 10);
        // clear with an offered pair
        for (int i = 0; i < 3; i++) step(1, i + 7, 2 * i, OP_SUB);
        clear = 1;
        step(1, 99, 1, OP_ADD);
        clear = 0;
        for (int k = 0; k < 3; k++) begin
            step(0, 0, 0, OP_ADD);
            chk("t4_flushed", 0, 32'(d_valid[0]), 0);
            chk("t4_count", 0, 32'(d_cnt[0]), 11);
        end
        // asynchronous reset with work in flight
        step(1, 1, 2, OP_ADD);
        step(1, 3, 4, OP_SUB);
        #2 rst_n = 0;
        model_reset();
        #1;
        for (int g = 0; g < 3; g++) begin
            chk("t5_valid", g, 32'(d_valid[g]), 0);
            chk("t5_count", g, 32'(d_cnt[g]), 0);
        end
        step(0, 0, 0, OP_ADD);
        rst_n = 1;
        step(1, 40, 2, OP_SAT_SUB);
        chk("t5_lat1", 0, 32'(d_valid[0]), 0);
        step(0, 0, 0, OP_ADD);
        chk("t5_lat2", 0, 32'(d_valid[0]), 0);
        step(0, 0, 0, OP_ADD);
        chk("t5_valid", 0, 32'(d_valid[0]), 1);
        chk("t5_sum", 0, 32'(d_sum[0]), 38);
        // counter wrap and single-stage latency
        rst_n = 0;
        model_reset();
        step(0, 0, 0, OP_ADD);
        rst_n = 1;
        step(1, 255, 1, OP_ADD);
        chk("t6_s1_valid", 2, 32'(d_valid[2]), 1);
        chk("t6_s1_sum", 2, 32'(d_sum[2]), 256);
        chk("t6_s1_flag", 2, 32'(d_flag[2]), 1);
        chk("t6_s3_early", 0, 32'(d_valid[0]), 0);
        for (int i = 0; i < 16; i++) step(1, i, 3, OP_ADD);
        repeat (4) step(0, 0, 0, OP_ADD);
        chk("t6_wrap", 1, 32'(d_cnt[1]), 1);
        chk("t6_cnt", 0, 32'(d_cnt[0]), 17);
        chk("t6_cnt", 2, 32'(d_cnt[2]), 17);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
